// File: rtl/rv_pkg.sv
// rv_pkg: shared widths, the NOP encoding and the fetch FSM state type.
package rv_pkg;
    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, VALID} fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: pc-stage, instruction-memory and decode signals of the fetch stage.
// instr_fault_o exists only when FETCH_MISALIGN_FAULT_EN is defined.
interface fetch_unit_if;
    import rv_pkg::*;
    logic [XLEN-1:0] pc_i;
    logic            pc_adv_o;
    logic            flush_i;
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [ILEN-1:0] imem_rdata_i;
    logic            instr_valid_o;
    logic [ILEN-1:0] instr_o;
    logic [XLEN-1:0] instr_pc_o;
    logic            instr_ready_i;
`ifdef FETCH_MISALIGN_FAULT_EN
    logic            instr_fault_o;
`endif
    modport master (
        input  pc_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
        output pc_adv_o, imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o
`ifdef FETCH_MISALIGN_FAULT_EN
      , output instr_fault_o
`endif
    );
    modport slave (
        output pc_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
        input  pc_adv_o, imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o
`ifdef FETCH_MISALIGN_FAULT_EN
      , input  instr_fault_o
`endif
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: fetch stage issuing req/gnt/rvalid transactions and holding the instruction for decode.
// FETCH_MISALIGN_FAULT_EN turns a misaligned PC into a faulting NOP instead of a memory request.
module fetch_unit
    import rv_pkg::*;
(
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    fetch_state_t    state, next_state;
    logic [XLEN-1:0] addr_q, addr;
    logic [ILEN-1:0] instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic            first_q, drop_q, misalign;

`ifdef FETCH_MISALIGN_FAULT_EN
    logic fault_q;
    assign misalign          = first_q && bus.pc_i[1:0] != 2'b00;
    assign bus.instr_fault_o = fault_q;
`else
    assign misalign = 1'b0;
`endif

    // The pc stage updates on the edge that enters REQ, so the first REQ cycle sees pc_i live.
    assign addr              = first_q ? bus.pc_i : addr_q;
    assign bus.imem_req_o    = state == REQ && !misalign;
    assign bus.imem_addr_o   = addr;
    assign bus.instr_valid_o = state == VALID;
    assign bus.instr_o       = instr_q;
    assign bus.instr_pc_o    = instr_pc_q;
    assign bus.pc_adv_o      = state == VALID && bus.instr_ready_i && !bus.flush_i;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  next_state = REQ;
            REQ:   if (misalign) next_state = bus.flush_i ? IDLE : VALID;
                   else if (bus.imem_gnt_i) next_state = (drop_q || bus.flush_i) ? DRAIN : WAIT;
            WAIT:  if (bus.imem_rvalid_i) next_state = bus.flush_i ? REQ : VALID;
                   else if (bus.flush_i) next_state = DRAIN;
            DRAIN: if (bus.imem_rvalid_i) next_state = REQ;
            VALID: if (bus.flush_i || bus.instr_ready_i) next_state = REQ;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            first_q    <= 1'b0;
            drop_q     <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
`ifdef FETCH_MISALIGN_FAULT_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            state   <= next_state;
            first_q <= next_state == REQ && state != REQ;
            // A flush seen while the request waits for gnt marks its response as stale.
            drop_q  <= state == REQ && next_state == REQ && (drop_q || bus.flush_i);
            if (state == REQ) addr_q <= addr;
            if (state == WAIT && bus.imem_rvalid_i && !bus.flush_i) begin
                instr_q    <= bus.imem_rdata_i;
                instr_pc_q <= addr_q;
`ifdef FETCH_MISALIGN_FAULT_EN
                fault_q    <= 1'b0;
`endif
            end
`ifdef FETCH_MISALIGN_FAULT_EN
            if (misalign && !bus.flush_i) begin
                instr_q    <= NOP_INSTR;
                instr_pc_q <= bus.pc_i;
                fault_q    <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: fetch stage bench with memory, pc-stage and decode-scoreboard models.
module tb_fetch_unit;
    import rv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if bus();
    fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int gnt_wait = 0;
    int rv_lat = 1;
    logic ovr_en = 1'b0;
    logic [31:0] ovr_data = '0;
    logic jitter = 1'b0;
    logic [63:0] flush_target = '0;

    typedef struct packed {logic [31:0] instr; logic [63:0] pc;} exp_t;
    exp_t sb[$];

    typedef struct {int gw; int rl; int hold; logic [63:0] pc; logic [31:0] instr;} vec_t;
    vec_t vt[5];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return 32'h00500093 ^ {a[27:0], 4'h0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #2;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!bus.imem_req_o && n < 40) begin
            tick;
            n++;
        end
        chk(name, bus.imem_req_o, 1);
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (!bus.instr_valid_o && n < 40) begin
            tick;
            n++;
        end
        chk(name, bus.instr_valid_o, 1);
    endtask

    task automatic fetch_accept(input logic [63:0] pc);
        int n;
        sb.push_back({mem_word(pc), pc});
        wait_valid("fetch_valid", n);
        bus.instr_ready_i = 1'b1;
        #1;
        chk("fetch_adv", bus.pc_adv_o, 1);
        tick;
        bus.instr_ready_i = 1'b0;
    endtask

    // Instruction memory: configurable grant wait and response latency, one outstanding request.
    initial begin
        int wcnt, pcnt;
        logic hold;
        logic [63:0] haddr;
        logic [31:0] pdata;
        wcnt = 0; pcnt = 0; hold = 1'b0; haddr = '0; pdata = '0;
        bus.imem_gnt_i = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i = '0;
        forever begin
            @(negedge clk);
            #3;
            if (hold) begin
                checks++;
                if (!bus.imem_req_o || bus.imem_addr_o !== haddr) begin
                    errors++;
                    $display("FAIL req_hold: req %0b addr %0h expected req 1 addr %0h",
                             bus.imem_req_o, bus.imem_addr_o, haddr);
                end
            end
            bus.imem_gnt_i = 1'b0;
            bus.imem_rvalid_i = 1'b0;
            if (pcnt > 0) begin
                pcnt--;
                if (pcnt == 0) begin
                    bus.imem_rvalid_i = 1'b1;
                    bus.imem_rdata_i = pdata;
                end
            end
            if (bus.imem_req_o && pcnt == 0 && !bus.imem_rvalid_i) begin
                if (wcnt < gnt_wait) wcnt++;
                else begin
                    bus.imem_gnt_i = 1'b1;
                    wcnt = 0;
                    pcnt = rv_lat;
                    pdata = ovr_en ? ovr_data : mem_word(bus.imem_addr_o);
                end
            end else wcnt = 0;
            hold = bus.imem_req_o && !bus.imem_gnt_i;
            haddr = bus.imem_addr_o;
        end
    end

    // Pc stage: steps on pc_adv_o, loads the redirect target on flush, optionally drifts.
    initial begin
        logic adv, fl;
        bus.pc_i = '0;
        forever begin
            @(negedge clk);
            #4;
            adv = bus.pc_adv_o;
            fl = bus.flush_i;
            if (adv) begin
                checks++;
                if (!bus.instr_valid_o) begin
                    errors++;
                    $display("FAIL adv_outside_valid: pc_adv_o 1 with instr_valid_o 0");
                end
            end
            @(posedge clk);
            #1;
            if (fl) bus.pc_i = flush_target;
            else if (adv) bus.pc_i = bus.pc_i + 64'd4;
            else if (jitter) bus.pc_i = bus.pc_i + 64'h1000;
        end
    end

    // Decode scoreboard: every accepted instruction must match the oldest expectation.
    initial forever begin
        @(negedge clk);
        #4;
        if (bus.instr_valid_o && bus.instr_ready_i && !bus.flush_i) begin
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc %0h instr %0h expected none", bus.instr_pc_o, bus.instr_o);
            end else begin
                e = sb.pop_front();
                chk("sb_instr", bus.instr_o, e.instr);
                chk("sb_pc", bus.instr_pc_o, e.pc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic saw;
        vt[0] = '{0, 1, 0, 64'h0,  32'h00500093};
        vt[1] = '{0, 1, 4, 64'h4,  mem_word(64'h4)};
        vt[2] = '{2, 1, 1, 64'h8,  mem_word(64'h8)};
        vt[3] = '{0, 3, 0, 64'hc,  mem_word(64'hc)};
        vt[4] = '{1, 2, 2, 64'h10, mem_word(64'h10)};
        bus.instr_ready_i = 1'b0;
        bus.flush_i = 1'b0;

        repeat (3) @(negedge clk);
        #2;
        chk("rst_req", bus.imem_req_o, 0);
        chk("rst_addr", bus.imem_addr_o, 0);
        chk("rst_adv", bus.pc_adv_o, 0);
        chk("rst_valid", bus.instr_valid_o, 0);
        chk("rst_instr", bus.instr_o, 0);
        chk("rst_instr_pc", bus.instr_pc_o, 0);
`ifdef FETCH_MISALIGN_FAULT_EN
        chk("rst_fault", bus.instr_fault_o, 0);
`endif
        rst = 1'b0;

        foreach (vt[i]) begin
            gnt_wait = vt[i].gw;
            rv_lat = vt[i].rl;
            wait_req("vec_req");
            chk("vec_addr", bus.imem_addr_o, vt[i].pc);
            sb.push_back({vt[i].instr, vt[i].pc});
            wait_valid("vec_valid", n);
            chk("vec_latency", n, vt[i].gw + vt[i].rl + 1);
            repeat (vt[i].hold) begin
                tick;
                chk("hold_valid", bus.instr_valid_o, 1);
                chk("hold_instr", bus.instr_o, vt[i].instr);
                chk("hold_pc", bus.instr_pc_o, vt[i].pc);
                chk("hold_adv_req", {bus.pc_adv_o, bus.imem_req_o}, 0);
            end
            bus.instr_ready_i = 1'b1;
            #1;
            chk("vec_adv", bus.pc_adv_o, 1);
            tick;
            bus.instr_ready_i = 1'b0;
            chk("vec_after_valid", bus.instr_valid_o, 0);
        end

        // Grant delayed while pc_i drifts; then flush together with ready in VALID.
        gnt_wait = 3;
        rv_lat = 1;
        jitter = 1'b1;
        chk("jit_addr0", bus.imem_addr_o, 64'h14);
        repeat (3) begin
            tick;
            chk("jit_req", bus.imem_req_o, 1);
            chk("jit_addr", bus.imem_addr_o, 64'h14);
        end
        jitter = 1'b0;
        gnt_wait = 0;
        wait_valid("jit_valid", n);
        chk("jit_instr_pc", bus.instr_pc_o, 64'h14);
        chk("jit_instr", bus.instr_o, mem_word(64'h14));
        flush_target = 64'h200;
        bus.flush_i = 1'b1;
        bus.instr_ready_i = 1'b1;
        #1;
        chk("flush_ready_adv", bus.pc_adv_o, 0);
        tick;
        bus.flush_i = 1'b0;
        bus.instr_ready_i = 1'b0;
        chk("flush_ready_valid", bus.instr_valid_o, 0);
        chk("flush_ready_req", bus.imem_req_o, 1);
        chk("flush_ready_addr", bus.imem_addr_o, 64'h200);
        fetch_accept(64'h200);

        // Flush in WAIT, stale response two cycles later goes to DRAIN.
        rv_lat = 3;
        ovr_en = 1'b1;
        ovr_data = 32'hDEADBEEF;
        chk("drain_addr0", bus.imem_addr_o, 64'h204);
        tick;
        flush_target = 64'h100;
        bus.flush_i = 1'b1;
        tick;
        bus.flush_i = 1'b0;
        saw = 1'b0;
        n = 0;
        while (!bus.imem_req_o && n < 10) begin
            saw |= bus.instr_valid_o;
            tick;
            n++;
        end
        saw |= bus.instr_valid_o;
        chk("drain_no_valid", saw, 0);
        chk("drain_cycles", n, 2);
        chk("drain_addr", bus.imem_addr_o, 64'h100);
        ovr_en = 1'b0;
        rv_lat = 1;
        fetch_accept(64'h100);

        // Flush while the request still waits for gnt: the request stays, its response is dropped.
        gnt_wait = 2;
        flush_target = 64'h300;
        bus.flush_i = 1'b1;
        chk("reqflush_addr0", bus.imem_addr_o, 64'h104);
        tick;
        bus.flush_i = 1'b0;
        tick;
        chk("reqflush_hold", {bus.imem_req_o, bus.imem_addr_o}, {1'b1, 64'h104});
        tick;
        chk("reqflush_drain", {bus.imem_req_o, bus.instr_valid_o}, 0);
        tick;
        gnt_wait = 0;
        chk("reqflush_req", bus.imem_req_o, 1);
        chk("reqflush_addr", bus.imem_addr_o, 64'h300);
        fetch_accept(64'h300);

        // Flush and rvalid in the same WAIT cycle: straight back to REQ.
        chk("waitflush_addr0", bus.imem_addr_o, 64'h304);
        tick;
        flush_target = 64'h400;
        bus.flush_i = 1'b1;
        tick;
        bus.flush_i = 1'b0;
        chk("waitflush_valid", bus.instr_valid_o, 0);
        chk("waitflush_req", bus.imem_req_o, 1);
        chk("waitflush_addr", bus.imem_addr_o, 64'h400);
        fetch_accept(64'h400);

        // Redirect to a misaligned PC.
        flush_target = 64'h6;
        bus.flush_i = 1'b1;
        tick;
        bus.flush_i = 1'b0;
        tick;
`ifdef FETCH_MISALIGN_FAULT_EN
        chk("mis_no_req", bus.imem_req_o, 0);
        tick;
        chk("mis_valid", bus.instr_valid_o, 1);
        chk("mis_fault", bus.instr_fault_o, 1);
        chk("mis_instr", bus.instr_o, 32'h00000013);
        chk("mis_instr_pc", bus.instr_pc_o, 64'h6);
        flush_target = 64'h500;
        bus.flush_i = 1'b1;
        bus.instr_ready_i = 1'b1;
        #1;
        chk("mis_flush_adv", bus.pc_adv_o, 0);
        tick;
        bus.flush_i = 1'b0;
        bus.instr_ready_i = 1'b0;
        chk("mis_next_addr", {bus.imem_req_o, bus.imem_addr_o}, {1'b1, 64'h500});
        fetch_accept(64'h500);
`else
        chk("mis_req", bus.imem_req_o, 1);
        chk("mis_addr", bus.imem_addr_o, 64'h6);
        fetch_accept(64'h6);
`endif

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
